// File: rtl/temp_pkg.sv
// Shared types and default widths for the temperature averaging path.
// Also consumed by the 50 MHz write-side control.
package temp_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 11;
    localparam int AVG_N_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    function automatic int avg_shift(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_avg_writer_if.sv
// FIFO read side and RAM write side of the averaging writer.
// master = the writer, slave = the FIFO/RAM environment.
interface fifo_avg_writer_if
    import temp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd,
        output ram_wr,
        output ram_addr,
        output ram_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd,
        input  ram_wr,
        input  ram_addr,
        input  ram_data
    );

endinterface

// File: rtl/fifo_avg_writer_addr_dn_cnt.sv
// RAM address down-counter: resets/loads to all-ones, wraps 0 -> all-ones.
module addr_dn_cnt
    import temp_pkg::*;
#(
    parameter int W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    output logic [W-1:0] addr_o
);

    logic [W-1:0] addr_q;
    logic [W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = '1;
        end else if (dec_i) begin
            addr_d = addr_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '1;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/fifo_avg_writer.sv
// Reads AVG_N bytes from the temperature FIFO and writes their
// truncated mean to RAM at a descending address.
module fifo_avg_writer
    import temp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int AVG_N  = AVG_N_DEF
) (
    input  logic              clk,
    input  logic              reset,
    fifo_avg_writer_if.master bus
);

    localparam int SH    = avg_shift(AVG_N);
    localparam int ACC_W = DATA_W + SH;

    state_e            state_q;
    state_e            state_d;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  acc_sum;
    logic [SH-1:0]     cnt_q;
    logic [SH-1:0]     cnt_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              last_byte;
    logic              addr_dec;
    logic [ADDR_W-1:0] addr;

    // acc is SH bits wider than a byte, so AVG_N max bytes cannot overflow
    assign acc_sum   = acc_q + ACC_W'(bus.fifo_rd_data);
    assign last_byte = (cnt_q == SH'(AVG_N - 1));

    always_comb begin
        state_d  = ST_IDLE;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        addr_dec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = bus.fifo_empty ? ST_IDLE : ST_READ;
            end
            ST_READ: begin
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + SH'(1);
                if (last_byte) begin
                    // register the mean so it is stable through WRITE
                    data_d  = DATA_W'(acc_sum >> SH);
                    state_d = ST_WRITE;
                end else if (!bus.fifo_empty) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                acc_d    = '0;
                cnt_d    = '0;
                addr_dec = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    addr_dn_cnt #(
        .W (ADDR_W)
    ) u_addr (
        .clk    (clk),
        .rst    (reset),
        .load_i (1'b0),
        .dec_i  (addr_dec),
        .addr_o (addr)
    );

    assign bus.fifo_rd  = (state_q == ST_READ);
    assign bus.ram_wr   = (state_q == ST_WRITE);
    assign bus.ram_addr = addr;
    assign bus.ram_data = data_q;

endmodule

// File: tb/tb_fifo_avg_writer.sv
// Bench for fifo_avg_writer: queue-based FIFO model, write monitor
// and a reference mean/address model computed from the byte stream.
module tb_fifo_avg_writer;
    import temp_pkg::*;

    localparam int DW = 8;
    localparam int AW = 11;
    localparam int AN = 4;
    localparam int AMAX = (1 << AW) - 1;

    typedef struct {
        int data;
        int addr;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fifo_avg_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fifo_avg_writer #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .AVG_N  (AN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] fq[$];
    wr_t wq[$];
    int rdcyc[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int viol = 0;
    int uflow = 0;
    bit hold_empty = 1'b0;
    bit prev_empty = 1'b1;
    int exp_addr = AMAX;

    // FIFO model: data appears the cycle after the read strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd === 1'b1) begin
            if (fq.size() == 0) uflow++;
            else bus.fifo_rd_data <= fq.pop_front();
        end
    end

    always @(negedge clk) begin
        if (bus.fifo_rd === 1'b1) begin
            if (prev_empty) viol++;
            rdcyc.push_back(cyc);
        end
        if (bus.ram_wr === 1'b1)
            wq.push_back('{int'(bus.ram_data), int'(bus.ram_addr), cyc});
        bus.fifo_empty = hold_empty || (fq.size() == 0);
        prev_empty = bus.fifo_empty;
    end

    function automatic int mean(input int s);
        return s / AN;
    endfunction

    function automatic int next_addr(input int a);
        return (a == 0) ? AMAX : a - 1;
    endfunction

    task automatic wait_wr(input int n, input int budget, output bit ok);
        int k = 0;
        while (wq.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (wq.size() >= n);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        fq.delete();
        hold_empty = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        wq.delete();
        rdcyc.delete();
        exp_addr = AMAX;
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (bus.fifo_rd !== 1'b0 || bus.ram_wr !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes: rd=%b wr=%b required 0 0", bus.fifo_rd, bus.ram_wr);
        end
        total++;
        if (bus.ram_addr !== AW'(AMAX)) begin
            bad++;
            $display("FAIL reset_addr: got %h required %h", bus.ram_addr, AMAX);
        end
        total++;
        if (bus.ram_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h required 0", bus.ram_data);
        end
        release_reset();
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (rdcyc.size() != 0 || wq.size() != 0) begin
            bad++;
            $display("FAIL reset_idle: rd=%0d wr=%0d required 0 0", rdcyc.size(), wq.size());
        end
    endtask

    task automatic test_basic();
        bit ok;
        int b[4] = '{10, 20, 30, 40};
        foreach (b[i]) fq.push_back(DW'(b[i]));
        wait_wr(1, 60, ok);
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (!ok || wq.size() != 1) begin
            bad++;
            $display("FAIL basic_pulses: got %0d required 1", wq.size());
        end else begin
            total++;
            if (wq[0].data != 25 || wq[0].addr != exp_addr) begin
                bad++;
                $display("FAIL basic_value: data=%0d addr=%h required 25 %h",
                         wq[0].data, wq[0].addr, exp_addr);
            end
            total++;
            if (rdcyc.size() != 4 || wq[0].cyc - rdcyc[0] != 8 || rdcyc[3] - rdcyc[0] != 6) begin
                bad++;
                $display("FAIL basic_timing: reads=%0d span=%0d required 4 8",
                         rdcyc.size(), wq[0].cyc - rdcyc[0]);
            end
        end
        exp_addr = next_addr(exp_addr);
        wq.delete();
        rdcyc.delete();
    endtask

    task automatic test_overflow_trunc();
        bit ok;
        int b[8] = '{255, 255, 255, 255, 1, 1, 1, 2};
        int e[2] = '{255, 1};
        foreach (b[i]) fq.push_back(DW'(b[i]));
        wait_wr(2, 80, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ovf_timeout: got %0d writes required 2", wq.size());
        end
        for (int i = 0; i < 2 && i < wq.size(); i++) begin
            total++;
            if (wq[i].data != e[i] || wq[i].addr != exp_addr) begin
                bad++;
                $display("FAIL ovf_trunc_%0d: data=%0d addr=%h required %0d %h",
                         i, wq[i].data, wq[i].addr, e[i], exp_addr);
            end
            exp_addr = next_addr(exp_addr);
        end
        wq.delete();
        rdcyc.delete();
    endtask

    task automatic test_empty_idle();
        bit ok;
        int c0;
        int lat;
        int s;
        logic [DW-1:0] b;
        repeat (100) @(posedge clk);
        #1;
        total++;
        if (rdcyc.size() != 0 || wq.size() != 0) begin
            bad++;
            $display("FAIL empty_idle: rd=%0d wr=%0d required 0 0", rdcyc.size(), wq.size());
        end
        b = DW'($urandom_range(0, 255));
        s = int'(b);
        c0 = cyc;
        fq.push_back(b);
        repeat (3) @(posedge clk);
        #1;
        lat = (rdcyc.size() > 0) ? rdcyc[0] - c0 : 999;
        total++;
        if (lat > 2) begin
            bad++;
            $display("FAIL empty_wake: latency=%0d required <=2", lat);
        end
        for (int i = 0; i < 3; i++) begin
            b = DW'($urandom_range(0, 255));
            s += int'(b);
            fq.push_back(b);
        end
        wait_wr(1, 60, ok);
        total++;
        if (!ok || wq[0].data != mean(s) || wq[0].addr != exp_addr) begin
            bad++;
            $display("FAIL empty_avg: data=%0d required %0d", ok ? wq[0].data : -1, mean(s));
        end
        exp_addr = next_addr(exp_addr);
        wq.delete();
        rdcyc.delete();
    endtask

    task automatic test_back_to_back();
        localparam int NW = (1 << AW) + 1;
        int e[NW];
        bit ok;
        int a;
        int s;
        int nerr;
        logic [DW-1:0] b;
        reset = 1'b1;
        release_reset();
        for (int g = 0; g < NW; g++) begin
            s = 0;
            for (int j = 0; j < AN; j++) begin
                b = DW'($urandom_range(0, 255));
                s += int'(b);
                fq.push_back(b);
            end
            e[g] = mean(s);
        end
        wait_wr(NW, NW * 10 + 50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_timeout: got %0d writes required %0d", wq.size(), NW);
        end
        a = AMAX;
        nerr = 0;
        for (int i = 0; i < NW && i < wq.size(); i++) begin
            total++;
            if (wq[i].data != e[i] || wq[i].addr != a) begin
                bad++;
                nerr++;
                if (nerr < 10)
                    $display("FAIL b2b_%0d: data=%0d addr=%h required %0d %h",
                             i, wq[i].data, wq[i].addr, e[i], a);
            end
            a = next_addr(a);
        end
        if (ok) begin
            total++;
            if (wq[NW-1].addr != AMAX || wq[NW-1].cyc - wq[0].cyc != (NW - 1) * 10) begin
                bad++;
                $display("FAIL b2b_wrap: addr=%h span=%0d required %h %0d",
                         wq[NW-1].addr, wq[NW-1].cyc - wq[0].cyc, AMAX, (NW - 1) * 10);
            end
        end
        exp_addr = a;
        wq.delete();
        rdcyc.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        fq.push_back(DW'(200));
        fq.push_back(DW'(100));
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.ram_addr !== AW'(AMAX) || bus.ram_data !== '0 || bus.fifo_rd !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: addr=%h data=%h rd=%b required %h 0 0",
                     bus.ram_addr, bus.ram_data, bus.fifo_rd, AMAX);
        end
        release_reset();
        for (int i = 0; i < 4; i++) fq.push_back(DW'(8));
        wait_wr(1, 60, ok);
        total++;
        if (!ok || wq[0].data != 8 || wq[0].addr != AMAX) begin
            bad++;
            $display("FAIL rstmid_avg: data=%0d addr=%h required 8 %h",
                     ok ? wq[0].data : -1, ok ? wq[0].addr : -1, AMAX);
        end
        exp_addr = next_addr(exp_addr);
        wq.delete();
        rdcyc.delete();
    endtask

    task automatic test_toggle_empty();
        int e[3];
        int s;
        int v0;
        int k;
        logic [DW-1:0] b;
        v0 = viol;
        hold_empty = 1'b1;
        for (int g = 0; g < 3; g++) begin
            s = 0;
            for (int j = 0; j < AN; j++) begin
                b = DW'($urandom_range(0, 255));
                s += int'(b);
                fq.push_back(b);
            end
            e[g] = mean(s);
        end
        k = 0;
        while (wq.size() < 3 && k < 600) begin
            @(posedge clk);
            #1;
            hold_empty = ($urandom_range(0, 2) != 0);
            k++;
        end
        hold_empty = 1'b0;
        total++;
        if (wq.size() < 3) begin
            bad++;
            $display("FAIL toggle_timeout: got %0d writes required 3", wq.size());
        end
        total++;
        if (viol != v0) begin
            bad++;
            $display("FAIL toggle_rd_empty: got %0d reads while empty required 0", viol - v0);
        end
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            total++;
            if (wq[i].data != e[i] || wq[i].addr != exp_addr) begin
                bad++;
                $display("FAIL toggle_%0d: data=%0d addr=%h required %0d %h",
                         i, wq[i].data, wq[i].addr, e[i], exp_addr);
            end
            exp_addr = next_addr(exp_addr);
        end
        wq.delete();
        rdcyc.delete();
    endtask

    task automatic test_random_gaps();
        bit ok;
        int ng;
        int s;
        int e[$];
        logic [DW-1:0] b;
        ng = $urandom_range(3, 8);
        for (int g = 0; g < ng; g++) begin
            s = 0;
            for (int j = 0; j < AN; j++) begin
                b = DW'($urandom_range(0, 255));
                s += int'(b);
                fq.push_back(b);
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
            e.push_back(mean(s));
        end
        wait_wr(ng, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL gaps_timeout: got %0d writes required %0d", wq.size(), ng);
        end
        for (int i = 0; i < ng && i < wq.size(); i++) begin
            total++;
            if (wq[i].data != e[i] || wq[i].addr != exp_addr) begin
                bad++;
                $display("FAIL gaps_%0d: data=%0d addr=%h required %0d %h",
                         i, wq[i].data, wq[i].addr, e[i], exp_addr);
            end
            exp_addr = next_addr(exp_addr);
        end
        total++;
        if (viol != 0 || uflow != 0) begin
            bad++;
            $display("FAIL protocol: rd_while_empty=%0d underflow=%0d required 0 0", viol, uflow);
        end
        wq.delete();
        rdcyc.delete();
    endtask

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_rd_data = '0;
        test_reset();
        test_basic();
        test_overflow_trunc();
        test_empty_idle();
        test_back_to_back();
        test_reset_mid();
        test_toggle_empty();
        test_random_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
